// File: rtl/fetch_queue_stage_pkg.sv
// Shared pipeline types for the queued fetch stage.
package fetch_queue_stage_pkg;

  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned InstrWidth = 32;

  typedef logic                  clock_t;
  typedef logic                  bool_t;
  typedef logic [AddrWidth-1:0]  addr_t;
  typedef logic [InstrWidth-1:0] instr_t;

  // Canonical no-op (addi x0, x0, 0) shown to decode when nothing is valid.
  localparam instr_t NOP = 32'h0000_0013;

  typedef struct packed {
    instr_t instr;
    addr_t  next_address;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_fifo.sv
// Power-of-two synchronous FIFO of fetch entries with synchronous clear.
module fetch_entry_fifo
  import fetch_queue_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  clock_t                   clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t          mem_q [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, push and pop hit the same slot; the head is read before the write lands.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage with PC, credit-limited memory requests and a decode-facing entry queue.
// Optional same-cycle response bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter addr_t       RESET_VECTOR    = '0,
  parameter addr_t       ADDR_STEP       = addr_t'(4)
) (
  input  clock_t clk,
  input  logic   reset_n,
  input  logic   jump_enable,
  input  addr_t  jump_address,
  output logic   mem_req_valid,
  input  logic   mem_req_ready,
  output addr_t  mem_req_address,
  input  logic   mem_resp_valid,
  input  instr_t mem_resp_instr,
  output logic   out_valid,
  input  logic   out_ready,
  output instr_t instruction_out,
  output addr_t  next_address_out
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  typedef logic [CntW-1:0] cnt_t;

  addr_t pc_q, pc_d;
  addr_t resp_pc_q, resp_pc_d;
  cnt_t  outstanding_q, outstanding_d;
  cnt_t  drop_q, drop_d;

  cnt_t         count;
  fetch_entry_t head;
  fetch_entry_t push_data;
  bool_t        push, pop, fire, resp_keep, resp_drop, bypass;

  // Credits cover queue slots already promised to in-flight requests.
  assign mem_req_valid = reset_n & !jump_enable
                       & (int'(outstanding_q) < int'(MAX_OUTSTANDING))
                       & ((int'(count) + int'(outstanding_q)) < int'(DEPTH));
  assign mem_req_address = pc_q;
  assign fire            = mem_req_valid & mem_req_ready;

  assign resp_keep = mem_resp_valid & (drop_q == '0);
  assign resp_drop = mem_resp_valid & (drop_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = reset_n & resp_keep & (count == '0) & !jump_enable;
`else
  assign bypass = 1'b0;
`endif

  assign push_data = '{instr: mem_resp_instr, next_address: resp_pc_q + ADDR_STEP};

  always_comb begin
    out_valid        = 1'b0;
    instruction_out  = NOP;
    next_address_out = '0;
    if (bypass) begin
      out_valid        = 1'b1;
      instruction_out  = push_data.instr;
      next_address_out = push_data.next_address;
    end else if ((count != '0) && !jump_enable) begin
      out_valid        = 1'b1;
      instruction_out  = head.instr;
      next_address_out = head.next_address;
    end
  end

  assign push = resp_keep & !jump_enable & !(bypass & out_ready);
  assign pop  = !bypass & out_valid & out_ready;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (jump_enable) begin
      pc_d          = jump_address;
      resp_pc_d     = jump_address;
      // Everything still in flight after this cycle belongs to the old stream.
      outstanding_d = outstanding_q - cnt_t'(mem_resp_valid);
      drop_d        = outstanding_q - cnt_t'(mem_resp_valid);
    end else begin
      if (fire)      pc_d      = pc_q + ADDR_STEP;
      if (resp_keep) resp_pc_d = resp_pc_q + ADDR_STEP;
      outstanding_d = outstanding_q + cnt_t'(fire) - cnt_t'(mem_resp_valid);
      drop_d        = drop_q - cnt_t'(resp_drop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (jump_enable),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with an in-order, fixed-latency memory model.
module tb_fetch_queue_stage;
  import fetch_queue_stage_pkg::*;

  logic   clk = 1'b0;
  logic   reset_n;
  logic   jump_enable;
  addr_t  jump_address;
  logic   mem_req_valid;
  logic   mem_req_ready;
  addr_t  mem_req_address;
  logic   mem_resp_valid;
  instr_t mem_resp_instr;
  logic   out_valid;
  logic   out_ready;
  instr_t instruction_out;
  addr_t  next_address_out;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int lat   = 1;
  addr_t pend_addr[$];
  int    pend_due[$];

  fetch_queue_stage #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_VECTOR    (32'h0000_0100),
    .ADDR_STEP       (32'd4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .jump_enable      (jump_enable),
    .jump_address     (jump_address),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_address  (mem_req_address),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_instr   (mem_resp_instr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .instruction_out  (instruction_out),
    .next_address_out (next_address_out)
  );

  always #5 clk = ~clk;

  function automatic instr_t mem_word(input addr_t a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present();
    if (pend_addr.size() > 0 && pend_due[0] <= cycle) begin
      mem_resp_valid = 1'b1;
      mem_resp_instr = mem_word(pend_addr[0]);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_instr = '0;
    end
  endtask

  task automatic mem_clear();
    pend_addr.delete();
    pend_due.delete();
    mem_resp_valid = 1'b0;
    mem_resp_instr = '0;
  endtask

  task automatic step();
    logic  fired, taken;
    addr_t a;
    #1;
    fired = mem_req_valid & mem_req_ready;
    a     = mem_req_address;
    taken = mem_resp_valid;
    @(posedge clk);
    #1;
    if (taken) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (fired) begin
      pend_addr.push_back(a);
      pend_due.push_back(cycle + lat);
    end
    cycle++;
    present();
  endtask

  task automatic wait_out_valid(input string tag);
    for (int k = 0; k < 20 && !out_valid; k++) step();
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle   = 0;
    present();
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    jump_enable   = 1'b0;
    jump_address  = '0;
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    mem_clear();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instruction_out, NOP);
    check("rst_next", next_address_out, 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);

    // Free-run with 1-cycle memory.
    reset_release();
    check("first_req_valid", 32'(mem_req_valid), 32'd1);
    check("first_req_addr", mem_req_address, 32'h100);
    step();
    check("fill_no_valid", 32'(out_valid), 32'd0);
    check("second_req_addr", mem_req_address, 32'h104);
    step();
    for (int i = 0; i < 4; i++) begin
      check("run_valid", 32'(out_valid), 32'd1);
      check("run_instr", instruction_out, mem_word(32'h100 + 32'(4 * i)));
      check("run_next", next_address_out, 32'h104 + 32'(4 * i));
      step();
    end

    // Backpressure: head held, queue fills, requests stop.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("hold_instr", instruction_out, mem_word(32'h110));
      step();
    end
    check("full_req_valid", 32'(mem_req_valid), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) check("drain_req_valid", 32'(mem_req_valid), 32'd0);
      check("drain_instr", instruction_out, mem_word(32'h110 + 32'(4 * i)));
      check("drain_next", next_address_out, 32'h114 + 32'(4 * i));
      step();
    end

    // Jump with two requests in flight on a 3-cycle memory.
    reset_n = 1'b0;
    mem_clear();
    lat = 3;
    reset_release();
    step();
    step();
    jump_enable  = 1'b1;
    jump_address = 32'h2000;
    #1;
    check("j1_out_valid", 32'(out_valid), 32'd0);
    check("j1_req_valid", 32'(mem_req_valid), 32'd0);
    step();
    jump_enable = 1'b0;
    #1;
    check("j1_req_addr", mem_req_address, 32'h2000);
    wait_out_valid("j1_wait");
    check("j1_instr", instruction_out, mem_word(32'h2000));
    check("j1_next", next_address_out, 32'h2004);
    step();
    check("j1_second_valid", 32'(out_valid), 32'd1);
    check("j1_second_instr", instruction_out, mem_word(32'h2004));

    // Jump coincident with an arriving response and a pop.
    lat = 1;
    for (int k = 0; k < 20 && !(out_valid && mem_resp_valid); k++) step();
    check("j2_setup", 32'(out_valid & mem_resp_valid), 32'd1);
    jump_enable  = 1'b1;
    jump_address = 32'h3000;
    #1;
    check("j2_out_valid", 32'(out_valid), 32'd0);
    check("j2_instr_nop", instruction_out, NOP);
    check("j2_req_valid", 32'(mem_req_valid), 32'd0);
    step();
    jump_enable = 1'b0;
    wait_out_valid("j2_wait");
    check("j2_instr", instruction_out, mem_word(32'h3000));
    check("j2_next", next_address_out, 32'h3004);
    step();
    check("j2_following", instruction_out, mem_word(32'h3004));

    // Asynchronous reset with the queue partly full.
    out_ready = 1'b0;
    step();
    step();
    check("mid_out_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_instr", instruction_out, NOP);
    check("async_next", next_address_out, 32'd0);
    check("async_req_valid", 32'(mem_req_valid), 32'd0);
    mem_clear();
    out_ready = 1'b1;
    reset_release();
    check("restart_req_valid", 32'(mem_req_valid), 32'd1);
    check("restart_req_addr", mem_req_address, 32'h100);
    wait_out_valid("restart_wait");
    check("restart_instr", instruction_out, mem_word(32'h100));

    // PC wraps past the top of the address space.
    step();
    step();
    jump_enable  = 1'b1;
    jump_address = 32'hFFFF_FFFC;
    step();
    jump_enable = 1'b0;
    #1;
    check("wrap_req_addr", mem_req_address, 32'hFFFF_FFFC);
    for (int k = 0; k < 20 && !mem_req_valid; k++) step();
    check("wrap_req_valid", 32'(mem_req_valid), 32'd1);
    step();
    check("wrap_next_req", mem_req_address, 32'h0000_0000);
    wait_out_valid("wrap_wait");
    check("wrap_instr", instruction_out, mem_word(32'hFFFF_FFFC));
    check("wrap_next", next_address_out, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
